// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch controller: opcode values, FSM state encoding
// and the branch-resolution helpers used by the control FSM.
package fetch_ctrl_pkg;

  localparam logic [3:0] OP_BR  = 4'hC;
  localparam logic [3:0] OP_BZ  = 4'hD;
  localparam logic [3:0] OP_BNZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_BZ) || (op == OP_BNZ);
  endfunction

  function automatic logic branch_taken(input logic [3:0] op, input logic flag_z);
    case (op)
      OP_BR:   return 1'b1;
      OP_BZ:   return flag_z;
      OP_BNZ:  return !flag_z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read port and decode hand-off bundled as one interface;
// master is the fetch controller, slave is the memory/decode side.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output imem_req, imem_addr, ir, ir_valid,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_valid,
    output imem_ack, imem_rdata, ir_ready
  );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Counts consecutive un-acked fetch cycles; expired flags the cycle in which
// the LIMIT-th such cycle completes without an ack.
module fetch_timeout_ctr #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] count_r;

  // Wait counter: clear wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= W'(0);
    end else if (clr) begin
      count_r <= W'(0);
    end else if (en) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = en && !clr && (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/branch control for the 12-bit PC: fetches at the PC, resolves relative
// branches and HLT locally, and offers every other instruction to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flag_z,
  fetch_ctrl_if.master      bus,
  output logic              sel_pc,
  output logic              ld_pc,
  output logic [7:0]        pc_off,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  logic [2:0]        state_r;
  logic [2:0]        next_s;
  logic [DATA_W-1:0] ir_r;
  logic [CNT_W-1:0]  retired_r;
  logic [3:0]        op_s;
  logic              taken_s;
  logic              imem_req_s;
  logic              ir_valid_s;
  logic              ld_pc_s;
  logic              sel_pc_s;
  logic [7:0]        pc_off_s;
  logic              retire_s;
  logic              tmo_en_s;
  logic              tmo_clr_s;
  logic              tmo_expired_s;

  assign op_s      = ir_r[DATA_W-1 -: 4];
  assign taken_s   = branch_taken(op_s, flag_z);
  assign tmo_en_s  = (state_r == ST_FETCH);
  assign tmo_clr_s = !tmo_en_s || bus.imem_ack;

  fetch_timeout_ctr #(
    .LIMIT (ACK_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr_s),
    .en      (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // Next-state and Mealy control decode
  always_comb begin
    next_s     = state_r;
    imem_req_s = 1'b0;
    ir_valid_s = 1'b0;
    ld_pc_s    = 1'b0;
    sel_pc_s   = 1'b0;
    pc_off_s   = 8'h00;
    retire_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          next_s = ST_FETCH;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.imem_ack) begin
          next_s = ST_EXEC;
        end else if (tmo_expired_s) begin
          next_s = ST_ERR;
        end else begin
          next_s = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (is_branch(op_s)) begin
          ld_pc_s  = 1'b1;
          sel_pc_s = taken_s;
          pc_off_s = taken_s ? ir_r[7:0] : 8'h00;
          retire_s = 1'b1;
          next_s   = run ? ST_FETCH : ST_IDLE;
        end else if (op_s == OP_HLT) begin
          // PC is left pointing at the HLT word
          retire_s = 1'b1;
          next_s   = ST_HALT;
        end else begin
          ir_valid_s = 1'b1;
          if (bus.ir_ready) begin
            ld_pc_s  = 1'b1;
            retire_s = 1'b1;
            next_s   = run ? ST_FETCH : ST_IDLE;
          end else begin
            next_s = ST_EXEC;
          end
        end
      end
      ST_HALT: next_s = ST_HALT;
      ST_ERR:  next_s = ST_ERR;
      default: next_s = ST_IDLE;
    endcase
  end

  // State, instruction register and retired counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ir_r      <= {DATA_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_s;
      if ((state_r == ST_FETCH) && bus.imem_ack) begin
        ir_r <= bus.imem_rdata;
      end else begin
        ir_r <= ir_r;
      end
      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign bus.imem_req  = imem_req_s;
  assign bus.imem_addr = imem_req_s ? pc_addr : {ADDR_W{1'b0}};
  assign bus.ir        = ir_r;
  assign bus.ir_valid  = ir_valid_s;
  assign ld_pc         = ld_pc_s;
  assign sel_pc        = sel_pc_s;
  assign pc_off        = pc_off_s;
  assign halted        = (state_r == ST_HALT);
  assign err           = (state_r == ST_ERR);
  assign retired       = retired_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: the bench plays PC, instruction memory
// and decode, and predicts each instruction's outcome from the opcode rules.
module tb_fetch_ctrl;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int ACK_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [ADDR_W-1:0] pc_addr;
  logic              flag_z;
  logic              sel_pc;
  logic              ld_pc;
  logic [7:0]        pc_off;
  logic              halted;
  logic              err;
  logic [CNT_W-1:0]  retired;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_retired = 0;
  int ld_seen = 0;

  fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .pc_addr(pc_addr), .flag_z(flag_z), .bus(bus),
    .sel_pc(sel_pc), .ld_pc(ld_pc), .pc_off(pc_off), .halted(halted), .err(err),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // One clock: the bench's PC follows the DUT's load request at the edge
  task automatic step();
    logic       ld_q;
    logic       sel_q;
    logic [7:0] off_q;
    ld_q = ld_pc; sel_q = sel_pc; off_q = pc_off;
    if (ld_q === 1'b1) ld_seen++;
    @(posedge clk); #1;
    if (ld_q === 1'b1) pc_addr = sel_q ? pc_addr + {{4{off_q[7]}}, off_q} : pc_addr + 12'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; flag_z = 1'b0; pc_addr = 12'h000;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000; bus.ir_ready = 1'b0;
    step(); step();
    rst = 1'b0; exp_retired = 0;
  endtask

  task automatic start();
    run = 1'b1; #1;
    step();
  endtask

  // Runs one instruction from the first FETCH cycle to the cycle after it retires
  task automatic do_instr(input logic [15:0] word, input int ack_lat, input int rdy_lat,
                          input logic fz, input logic drop_run);
    logic [3:0]  op;
    logic        tk;
    logic        exp_ld;
    logic [7:0]  exp_off;
    logic [11:0] pc0;
    logic [11:0] exp_pc;
    int          target;
    int          ld0;
    op  = word[15:12];
    pc0 = pc_addr;
    tk  = (op == 4'hC) || (op == 4'hD && fz) || (op == 4'hE && !fz);
    target = int'(pc0) + (op == 4'hF ? 0 : (tk ? int'($signed(word[7:0])) : 1));
    exp_pc  = target[11:0];
    exp_ld  = (op != 4'hF);
    exp_off = tk ? word[7:0] : 8'h00;
    ld0 = ld_seen;
    for (int c = 1; c <= ack_lat; c++) begin
      if (drop_run && c == 1) run = 1'b0;
      bus.imem_ack = (c == ack_lat);
      bus.imem_rdata = (c == ack_lat) ? word : ~word;
      #1;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc0 || ld_pc !== 1'b0 ||
          bus.ir_valid !== 1'b0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_cycle pc=%h c=%0d: req=%b addr=%h ld=%b irv=%b err=%b, want 1 %h 0 0 0",
                 pc0, c, bus.imem_req, bus.imem_addr, ld_pc, bus.ir_valid, err, pc0);
      end
      step();
    end
    flag_z = fz;
    if (op >= 4'hC) begin
      bus.imem_ack = 1'($urandom_range(0, 1)); bus.imem_rdata = ~word;
      #1;
      n_cmp++;
      if (ld_pc !== exp_ld || sel_pc !== tk || pc_off !== exp_off || bus.ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL exec_ctrl word=%h fz=%b: ld=%b sel=%b off=%h irv=%b, want %b %b %h 0",
                 word, fz, ld_pc, sel_pc, pc_off, bus.ir_valid, exp_ld, tk, exp_off);
      end
      step();
    end else begin
      for (int k = 0; k <= rdy_lat; k++) begin
        bus.ir_ready = (k == rdy_lat);
        bus.imem_ack = 1'($urandom_range(0, 1)); bus.imem_rdata = ~word;
        #1;
        n_cmp++;
        if (bus.ir_valid !== 1'b1 || bus.ir !== word || ld_pc !== (k == rdy_lat) ||
            sel_pc !== 1'b0 || pc_off !== 8'h00) begin
          n_fail++;
          $display("FAIL decode_handoff word=%h k=%0d: irv=%b ir=%h ld=%b sel=%b off=%h, want 1 %h %b 0 00",
                   word, k, bus.ir_valid, bus.ir, ld_pc, sel_pc, pc_off, word, (k == rdy_lat));
        end
        step();
      end
      bus.ir_ready = 1'b0;
    end
    bus.imem_ack = 1'b0;
    exp_retired++;
    n_cmp++;
    if (pc_addr !== exp_pc || retired !== CNT_W'(exp_retired) ||
        (ld_seen - ld0) != (exp_ld ? 1 : 0) || halted !== (op == 4'hF)) begin
      n_fail++;
      $display("FAIL retire word=%h: pc=%h ret=%0d ld_pulses=%0d halted=%b, want %h %0d %0d %b",
               word, pc_addr, retired, ld_seen - ld0, halted, exp_pc, exp_retired,
               exp_ld ? 1 : 0, (op == 4'hF));
    end
  endtask

  task automatic test_reset();
    do_reset();
    pc_addr = 12'h5A5; #1;
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.ir, bus.ir_valid, sel_pc, ld_pc, pc_off,
         halted, err, retired} !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b addr=%h ir=%h irv=%b sel=%b ld=%b off=%h h=%b e=%b ret=%0d, want all 0",
               bus.imem_req, bus.imem_addr, bus.ir, bus.ir_valid, sel_pc, ld_pc, pc_off,
               halted, err, retired);
    end
  endtask

  task automatic test_decode_op();
    do_reset();
    start();
    do_instr(16'h1234, 1, 1, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h001) begin
      n_fail++;
      $display("FAIL next_fetch_addr: req=%b addr=%h, want 1 001", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branches();
    logic [15:0] w;
    do_reset();
    pc_addr = 12'h010;
    start();
    do_instr(16'hC0FC, 1, 0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bus.imem_addr !== 12'h00C) begin
      n_fail++;
      $display("FAIL br_target: addr=%h, want 00C", bus.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      w = (i < 2) ? 16'hD005 : 16'hE005;
      do_instr(w, 2, 0, 1'(i % 2), 1'b0);
    end
    do_instr(16'hC000, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    do_reset();
    pc_addr = 12'h020;
    start();
    do_instr(16'hF000, 2, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      run = 1'b1; #1;
      n_cmp++;
      if (bus.imem_req !== 1'b0 || ld_pc !== 1'b0 || halted !== 1'b1 || retired !== 16'd1) begin
        n_fail++;
        $display("FAIL halt_hold: req=%b ld=%b halted=%b ret=%0d, want 0 0 1 1",
                 bus.imem_req, ld_pc, halted, retired);
      end
      step();
    end
    rst = 1'b1; step(); rst = 1'b0; exp_retired = 0;
    n_cmp++;
    if (halted !== 1'b0 || retired !== 16'd0 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: halted=%b ret=%0d req=%b, want 0 0 0", halted, retired, bus.imem_req);
    end
    step(); #1;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h020) begin
      n_fail++;
      $display("FAIL halt_restart: req=%b addr=%h, want 1 020", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start();
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      bus.imem_ack = 1'b0; #1;
      n_cmp++;
      if (bus.imem_req !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait c=%0d: req=%b err=%b, want 1 0", c, bus.imem_req, err);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234; bus.ir_ready = 1'b1; #1;
      n_cmp++;
      if (err !== 1'b1 || bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0 ||
          ld_pc !== 1'b0 || retired !== 16'd0) begin
        n_fail++;
        $display("FAIL timeout_err: err=%b req=%b irv=%b ld=%b ret=%0d, want 1 0 0 0 0",
                 err, bus.imem_req, bus.ir_valid, ld_pc, retired);
      end
      step();
    end
    bus.imem_ack = 1'b0; bus.ir_ready = 1'b0;
    do_reset();
    start();
    do_instr(16'h0ABC, ACK_TIMEOUT, 0, 1'b0, 1'b0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack_boundary: err=%b, want 0", err);
    end
  endtask

  task automatic test_run_drop();
    do_reset();
    start();
    do_instr(16'h2222, 3, 1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.imem_req !== 1'b0 || ld_pc !== 1'b0) begin
        n_fail++;
        $display("FAIL run_drop_idle: req=%b ld=%b, want 0 0", bus.imem_req, ld_pc);
      end
      step();
    end
    start();
    bus.imem_ack = 1'b0; #1;
    n_cmp++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 12'h001) begin
      n_fail++;
      $display("FAIL resume_fetch: req=%b addr=%h, want 1 001", bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1; step(); rst = 1'b0; exp_retired = 0; #1;
    n_cmp++;
    if ({bus.imem_req, bus.imem_addr, bus.ir, bus.ir_valid, sel_pc, ld_pc, pc_off,
         halted, err, retired} !== 59'd0) begin
      n_fail++;
      $display("FAIL mid_fetch_reset: req=%b ir=%h ld=%b ret=%0d, want all 0",
               bus.imem_req, bus.ir, ld_pc, retired);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    pc_addr = 12'($urandom);
    start();
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 14));
      do_instr({op, 12'($urandom)}, $urandom_range(1, 4), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_decode_op();
    test_branches();
    test_halt();
    test_timeout();
    test_run_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
